// File: rtl/rll_pkg.sv
// Shared types and defaults for the key-gated wire block.
package rll_pkg;

    localparam int          DEF_KEY_W    = 16;
    localparam logic [15:0] DEF_INV_MASK = 16'h00A5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FULL   = 2'd2,
        ST_COMMIT = 2'd3
    } rll_state_e;

    // Width of the beat counter; never below one bit.
    function automatic int cnt_w(input int key_w);
        return (key_w < 2) ? 1 : $clog2(key_w);
    endfunction

endpackage

// File: rtl/rll_key_shift.sv
// Shadow key register: serial LSB-first fill with a wrapping beat counter.
module rll_key_shift
    import rll_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             beat_en,
    input  logic             beat_bit,
    output logic [KEY_W-1:0] shadow,
    output logic             beat_last
);

    localparam int CW = cnt_w(KEY_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(KEY_W - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;

    assign shadow    = shadow_q;
    assign beat_last = beat_en && (cnt_q == CNT_LAST);

    // Clear has priority over a beat; the counter wraps after the last bit.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clr) begin
            shadow_d = '0;
            cnt_d    = '0;
        end else if (beat_en) begin
            shadow_d[cnt_q] = beat_bit;
            cnt_d           = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Shadow and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rll_key_reg.sv
// Key load/commit controller and XOR/XNOR key gating of the protected wires.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no load in progress, ready for the first key beat
//   ST_SHIFT  | key beats arriving, shadow partially filled
//   ST_FULL   | shadow holds a complete key, waiting for key_commit
//   ST_COMMIT | one cycle: shadow copied into active key
module rll_key_reg
    import rll_pkg::*;
#(
    parameter int               KEY_W    = DEF_KEY_W,
    parameter logic [KEY_W-1:0] INV_MASK = KEY_W'(DEF_INV_MASK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sin_valid,
    input  logic             key_sin_data,
    output logic             key_sin_ready,
    input  logic             key_commit,
    input  logic             key_clr,
    input  logic [KEY_W-1:0] data_in,
    output logic [KEY_W-1:0] data_out,
    output logic             key_loaded,
    output logic             key_err
);

    rll_state_e       state_q, state_d;
    logic [KEY_W-1:0] active_key_q, active_key_d;
    logic [KEY_W-1:0] data_out_q, data_out_d;
    logic             key_loaded_q, key_loaded_d;
    logic             key_err_q, key_err_d;

    logic [KEY_W-1:0] shadow;
    logic             beat_last;
    logic             clr_eff;
    logic             beat_en;

    // A commit cycle cannot be aborted, so clear is masked there.
    assign clr_eff       = key_clr && (state_q != ST_COMMIT);
    assign key_sin_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_SHIFT));
    assign beat_en       = key_sin_valid && key_sin_ready && !clr_eff;

    rll_key_shift #(.KEY_W(KEY_W)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_eff),
        .beat_en   (beat_en),
        .beat_bit  (key_sin_data),
        .shadow    (shadow),
        .beat_last (beat_last)
    );

    // Next-state, key transfer and protocol-error detection.
    always_comb begin
        state_d      = state_q;
        active_key_d = active_key_q;
        key_loaded_d = key_loaded_q;
        key_err_d    = key_commit && (state_q != ST_FULL);
        unique case (state_q)
            ST_IDLE: begin
                if (beat_en) state_d = beat_last ? ST_FULL : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clr_eff)                  state_d = ST_IDLE;
                else if (beat_en && beat_last) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (clr_eff)         state_d = ST_IDLE;
                else if (key_commit) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                active_key_d = shadow;
                key_loaded_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Key gating: mask bit 1 behaves as XNOR, 0 as XOR.
    always_comb begin
        data_out_d = data_in ^ active_key_q ^ INV_MASK;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            active_key_q <= '0;
            data_out_q   <= '0;
            key_loaded_q <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_key_q <= active_key_d;
            data_out_q   <= data_out_d;
            key_loaded_q <= key_loaded_d;
            key_err_q    <= key_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign key_loaded = key_loaded_q;
    assign key_err    = key_err_q;

endmodule

// File: tb/tb_rll_key_reg.sv
// Directed bench for rll_key_reg at KEY_W=16 and KEY_W=32.
module tb_rll_key_reg;

    localparam logic [15:0] MASK16 = 16'h00A5;
    localparam logic [31:0] MASK32 = 32'h0000_00A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // KEY_W = 16 instance
    logic        rst, v, d, commit, clr;
    logic [15:0] din, dout;
    logic        ready, loaded, err;

    // KEY_W = 32 instance
    logic        b_rst, b_v, b_d, b_commit, b_clr;
    logic [31:0] b_din, b_dout;
    logic        b_ready, b_loaded, b_err;

    rll_key_reg dut16 (
        .clk (clk), .rst (rst),
        .key_sin_valid (v), .key_sin_data (d), .key_sin_ready (ready),
        .key_commit (commit), .key_clr (clr),
        .data_in (din), .data_out (dout),
        .key_loaded (loaded), .key_err (err)
    );

    rll_key_reg #(.KEY_W(32)) dut32 (
        .clk (clk), .rst (b_rst),
        .key_sin_valid (b_v), .key_sin_data (b_d), .key_sin_ready (b_ready),
        .key_commit (b_commit), .key_clr (b_clr),
        .data_in (b_din), .data_out (b_dout),
        .key_loaded (b_loaded), .key_err (b_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp16_q[$];
    logic [31:0] exp32_q[$];
    logic [15:0] model_key16;
    logic [31:0] model_key32;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load16(input logic [15:0] key, input int n);
        for (int i = 0; i < n; i++) begin
            v = 1'b1;
            d = key[i];
            chk("ready_during_load16", ready, 1'b1);
            tick();
        end
        v = 1'b0;
        d = 1'b0;
    endtask

    task automatic load32(input logic [31:0] key, input int n);
        for (int i = 0; i < n; i++) begin
            b_v = 1'b1;
            b_d = key[i];
            tick();
        end
        b_v = 1'b0;
        b_d = 1'b0;
    endtask

    task automatic send16(input string tag, input logic [15:0] x);
        logic [15:0] e;
        din = x;
        exp16_q.push_back(x ^ model_key16 ^ MASK16);
        tick();
        e = exp16_q.pop_front();
        chk(tag, dout, e);
    endtask

    task automatic send32(input string tag, input logic [31:0] x);
        logic [31:0] e;
        b_din = x;
        exp32_q.push_back(x ^ model_key32 ^ MASK32);
        tick();
        e = exp32_q.pop_front();
        chk(tag, b_dout, e);
    endtask

    task automatic commit16();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("ready_in_commit", ready, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1; v = 1'b0; d = 1'b0; commit = 1'b0; clr = 1'b0; din = '0;
        b_rst = 1'b1; b_v = 1'b0; b_d = 1'b0; b_commit = 1'b0; b_clr = 1'b0; b_din = '0;
        model_key16 = '0;
        model_key32 = '0;

        // Reset values
        tick(); tick();
        chk("ready_in_rst", ready, 1'b0);
        chk("dout_rst", dout, 16'h0000);
        chk("loaded_rst", loaded, 1'b0);
        chk("err_rst", err, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", ready, 1'b1);

        // Locked output before any commit
        send16("locked_1234", 16'h1234);
        chk("locked_1234_const", dout, 16'h1291);
        chk("loaded_before_commit", loaded, 1'b0);

        // Commit in IDLE: error pulse, key untouched
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("err_commit_idle", err, 1'b1);
        tick();
        chk("err_one_cycle", err, 1'b0);
        send16("key_unchanged_idle_commit", 16'h0000);

        // Full load of BEEF, valid in FULL ignored, then commit
        load16(16'hBEEF, 16);
        chk("ready_in_full", ready, 1'b0);
        v = 1'b1;
        tick();
        v = 1'b0;
        chk("err_valid_in_full", err, 1'b0);
        chk("ready_full_hold", ready, 1'b0);
        commit16();
        chk("err_commit_full", err, 1'b0);
        chk("loaded_after_commit", loaded, 1'b1);
        chk("ready_after_commit", ready, 1'b1);
        model_key16 = 16'hBEEF;
        send16("beef_gate_0000", 16'h0000);
        chk("beef_gate_const", dout, 16'hBE4A);

        // Partial load aborted, then a fresh full load
        load16(16'hFFFF, 8);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ready_after_clr", ready, 1'b1);
        send16("clr_keeps_active", 16'h5A5A);
        load16(16'h0001, 16);
        commit16();
        model_key16 = 16'h0001;
        send16("key_0001_gate_0000", 16'h0000);
        send16("key_0001_gate_ffff", 16'hFFFF);

        // Clear and commit together in FULL: clear wins
        load16(16'h1357, 16);
        clr = 1'b1;
        commit = 1'b1;
        tick();
        clr = 1'b0;
        commit = 1'b0;
        chk("err_clr_commit_full", err, 1'b0);
        chk("ready_clr_commit_full", ready, 1'b1);
        tick();
        chk("loaded_kept_after_clr", loaded, 1'b1);
        send16("old_key_after_clr_commit", 16'h0000);

        // Clear together with a valid beat: beat dropped
        v = 1'b1;
        d = 1'b1;
        clr = 1'b1;
        tick();
        v = 1'b0;
        d = 1'b0;
        clr = 1'b0;
        load16(16'h8421, 16);
        commit16();
        model_key16 = 16'h8421;
        send16("beat_dropped_on_clr", 16'h0000);

        // Clear during COMMIT is ignored
        load16(16'hA5A5, 16);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("loaded_clr_in_commit", loaded, 1'b1);
        model_key16 = 16'hA5A5;
        send16("clr_ignored_in_commit", 16'h0000);

        // Reset in the middle of a load
        load16(16'hC3C3, 10);
        v = 1'b1;
        d = 1'b1;
        rst = 1'b1;
        #1;
        chk("ready_mid_rst", ready, 1'b0);
        tick();
        chk("dout_mid_rst", dout, 16'h0000);
        chk("loaded_mid_rst", loaded, 1'b0);
        chk("err_mid_rst", err, 1'b0);
        rst = 1'b0;
        v = 1'b0;
        d = 1'b0;
        #1;
        chk("ready_after_mid_rst", ready, 1'b1);
        model_key16 = '0;
        send16("locked_after_mid_rst", 16'h1234);

        // Same reset scenario at KEY_W = 32
        chk("w32_ready_in_rst", b_ready, 1'b0);
        b_rst = 1'b0;
        #1;
        chk("w32_ready_after_rst", b_ready, 1'b1);
        load32(32'hDEAD_BEEF, 10);
        b_v = 1'b1;
        b_d = 1'b1;
        b_rst = 1'b1;
        tick();
        chk("w32_dout_mid_rst", b_dout, 32'h0);
        chk("w32_loaded_mid_rst", b_loaded, 1'b0);
        chk("w32_err_mid_rst", b_err, 1'b0);
        b_rst = 1'b0;
        b_v = 1'b0;
        b_d = 1'b0;
        #1;
        chk("w32_ready_after_mid_rst", b_ready, 1'b1);
        send32("w32_locked", 32'h1234_5678);
        load32(32'hDEAD_BEEF, 32);
        chk("w32_ready_in_full", b_ready, 1'b0);
        b_commit = 1'b1;
        tick();
        b_commit = 1'b0;
        tick();
        chk("w32_loaded", b_loaded, 1'b1);
        model_key32 = 32'hDEAD_BEEF;
        send32("w32_key_gate", 32'h0000_0000);
        chk("w32_key_gate_const", b_dout, 32'hDEAD_BE4A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rll_key_reg.md
RLL_KEY_REG -- requirements
Module: rll_key_reg

Interface
REQ-001 The block SHALL have parameter KEY_W, default 16, meaning the key width and the protected-wire count (legal range 2..256).
REQ-002 The block SHALL have parameter INV_MASK, default 16'h00A5, KEY_W bits wide; bit i = 1 makes key gate i XNOR, bit i = 0 makes it XOR.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 key_sin_valid  in  1  serial key beat valid.
REQ-007 key_sin_data  in  1  serial key bit, LSB first.
REQ-008 key_sin_ready  out  1  block accepts a beat this cycle.
REQ-009 key_commit  in  1  single-cycle request to transfer the shadow key to the active key.
REQ-010 key_clr  in  1  abort the load; clears the shadow key and the beat count.
REQ-011 data_in  in  KEY_W  protected wires.
REQ-012 data_out  out  KEY_W  registered key-gated wires.
REQ-013 key_loaded  out  1  active key has been committed at least once since reset.
REQ-014 key_err  out  1  one-cycle pulse flagging a protocol violation.

Function
REQ-015 The state machine SHALL have states IDLE, SHIFT, FULL and COMMIT.
REQ-016 A beat SHALL transfer when key_sin_valid and key_sin_ready are both 1 in the same cycle.
REQ-017 Each transferred beat SHALL be written to shadow[cnt], then cnt increments.
REQ-018 key_sin_ready SHALL be 1 in IDLE and SHIFT, and 0 in FULL and COMMIT.
REQ-019 IDLE SHALL go to SHIFT on the first transferred beat.
REQ-020 SHIFT SHALL go to FULL on the cycle the beat with cnt = KEY_W-1 transfers; cnt then wraps to 0.
REQ-021 In FULL, key_commit SHALL go to COMMIT; otherwise the state holds.
REQ-022 COMMIT SHALL last exactly one cycle: active_key <= shadow, key_loaded <= 1, next state IDLE.
REQ-023 The shadow key SHALL be retained after commit until the next load overwrites it.
REQ-024 data_out SHALL equal data_in ^ active_key ^ INV_MASK, registered, with latency 1 cycle.
REQ-025 data_out SHALL reflect the new active_key from the cycle after COMMIT onward; the wrong key gives corrupted output and no error.
REQ-026 key_commit outside FULL SHALL be ignored and SHALL pulse key_err for 1 cycle.
REQ-027 A transferred beat is impossible in FULL because ready is 0; key_sin_valid in FULL SHALL set no error.
REQ-028 key_clr in any state except COMMIT SHALL zero the shadow key and cnt and go to IDLE; active_key and key_loaded SHALL be unchanged.
REQ-029 When key_clr and key_commit are both 1 in FULL, key_clr SHALL win; no commit and no key_err.
REQ-030 When key_clr is 1 together with a valid beat, key_clr SHALL win and the beat SHALL be dropped.
REQ-031 key_clr in COMMIT SHALL be ignored.

Reset
REQ-032 rst SHALL set: state IDLE, cnt 0, shadow 0, active_key 0, data_out 0, key_loaded 0, key_err 0.
REQ-033 key_sin_ready SHALL be 0 during rst and 1 in the first cycle after rst deasserts.
REQ-034 rst mid-load or mid-commit SHALL discard all key state.
REQ-035 Before the first commit, data_out SHALL equal data_in ^ INV_MASK, i.e. the locked output.

Structure
REQ-036 Package rll_pkg SHALL hold the state enum, the KEY_W and INV_MASK defaults, and the function clog2-based cnt width.
REQ-037 Sub-module rll_key_shift SHALL hold the shadow register, cnt and the full detect; the top holds the FSM, active_key and the output gating.

Verification
REQ-038 Scenario: rst, then data_in=16'h1234 with no load -> data_out=16'h1291 one cycle later; key_loaded=0.
REQ-039 Scenario: shift 16 beats of 16'hBEEF LSB first, then key_commit -> key_loaded=1; data_in=16'h0000 gives data_out=16'hBE4A on the cycle after COMMIT+1.
REQ-040 Scenario: key_commit pulsed in IDLE -> key_err=1 for 1 cycle; active_key unchanged.
REQ-041 Scenario: load 8 beats then key_clr -> cnt=0, state IDLE; a following full load of 16'h0001 plus commit gives active_key=16'h0001.
REQ-042 Scenario: in FULL, key_clr and key_commit in the same cycle -> state IDLE; active_key keeps its old value; key_err=0.
REQ-043 Scenario: rst asserted during SHIFT beat 10 -> all outputs at reset values; ready=1 the next cycle; KEY_W=32 rerun passes identically.
